// File: rtl/debug_recolector_pkg.sv
// Shared definitions for the MIPS debug unit and its data collector.
// Both blocks take the dump length and state encoding from here.
package debug_recolector_pkg;

  localparam int DBG_LEN            = 32;
  localparam int DBG_CANT_REGS      = 32;
  localparam int DBG_CANT_MEM_DATOS = 16;

  // One-hot, 6 bits wide like the debug unit's own state register
  typedef enum logic [5:0] {
    REGS     = 6'b000001,
    MEM_REQ  = 6'b000010,
    MEM_WAIT = 6'b000100,
    MEM_HOLD = 6'b001000,
    DONE     = 6'b010000
  } dbg_state_e;

endpackage

// File: rtl/debug_recolector.sv
// Walks the register file and then data memory, presenting one word at a
// time to the debug unit's byte serializer.
module debug_recolector
  import debug_recolector_pkg::*;
#(
  parameter int LEN            = DBG_LEN,
  parameter int CANT_REGS      = DBG_CANT_REGS,
  parameter int CANT_MEM_DATOS = DBG_CANT_MEM_DATOS,
  parameter int NB_REG_ADDR    = $clog2(CANT_REGS),
  parameter int NB_MEM_ADDR    = $clog2(CANT_MEM_DATOS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic                   send_regs,
  input  logic                   enable_next,
  output logic [NB_REG_ADDR-1:0] reg_addr,
  input  logic [LEN-1:0]         reg_data,
  output logic [NB_MEM_ADDR-1:0] mem_addr,
  output logic                   mem_rd_en,
  input  logic [LEN-1:0]         mem_data,
  output logic [LEN-1:0]         data_out,
  output logic                   data_valid,
  output logic                   done
);

  localparam logic [NB_REG_ADDR-1:0] REG_LAST = NB_REG_ADDR'(CANT_REGS - 1);
  localparam logic [NB_MEM_ADDR-1:0] MEM_LAST = NB_MEM_ADDR'(CANT_MEM_DATOS - 1);

  dbg_state_e             state_r,      state_s;
  logic [NB_REG_ADDR-1:0] reg_idx_r,    reg_idx_s;
  logic [NB_MEM_ADDR-1:0] mem_idx_r,    mem_idx_s;
  logic [LEN-1:0]         data_out_r,   data_out_s;
  logic                   data_valid_r, data_valid_s;
  logic                   done_r,       done_s;
  logic                   mem_rd_en_r,  mem_rd_en_s;
  logic                   pending_r,    pending_s;

  // State and datapath registers; restart is folded into the next-state logic
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= REGS;
      reg_idx_r    <= {NB_REG_ADDR{1'b0}};
      mem_idx_r    <= {NB_MEM_ADDR{1'b0}};
      data_out_r   <= {LEN{1'b0}};
      data_valid_r <= 1'b0;
      done_r       <= 1'b0;
      mem_rd_en_r  <= 1'b0;
      pending_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      reg_idx_r    <= reg_idx_s;
      mem_idx_r    <= mem_idx_s;
      data_out_r   <= data_out_s;
      data_valid_r <= data_valid_s;
      done_r       <= done_s;
      mem_rd_en_r  <= mem_rd_en_s;
      pending_r    <= pending_s;
    end
  end

  // Next-state, pointer and data selection
  always_comb begin
    state_s      = state_r;
    reg_idx_s    = reg_idx_r;
    mem_idx_s    = mem_idx_r;
    data_out_s   = data_out_r;
    data_valid_s = data_valid_r;
    done_s       = done_r;
    mem_rd_en_s  = 1'b0;
    pending_s    = pending_r;

    if (restart) begin
      state_s      = REGS;
      reg_idx_s    = {NB_REG_ADDR{1'b0}};
      mem_idx_s    = {NB_MEM_ADDR{1'b0}};
      data_out_s   = {LEN{1'b0}};
      data_valid_s = 1'b0;
      done_s       = 1'b0;
      pending_s    = 1'b0;
    end else begin
      case (state_r)
        REGS: begin
          data_out_s = reg_data;
          // Dropping send_regs and advancing off the last register share one exit
          if (!send_regs || (enable_next && (reg_idx_r == REG_LAST))) begin
            state_s      = MEM_REQ;
            mem_idx_s    = {NB_MEM_ADDR{1'b0}};
            mem_rd_en_s  = 1'b1;
            data_valid_s = 1'b0;
          end else if (enable_next) begin
            reg_idx_s    = reg_idx_r + NB_REG_ADDR'(1);
            data_valid_s = 1'b0;
          end else begin
            data_valid_s = 1'b1;
          end
        end
        MEM_REQ: begin
          state_s = MEM_WAIT;
          if (enable_next) begin
            pending_s = 1'b1;
          end else begin
            pending_s = pending_r;
          end
        end
        MEM_WAIT: begin
          state_s      = MEM_HOLD;
          data_out_s   = mem_data;
          data_valid_s = 1'b1;
          if (enable_next) begin
            pending_s = 1'b1;
          end else begin
            pending_s = pending_r;
          end
        end
        MEM_HOLD: begin
          if (enable_next || pending_r) begin
            pending_s    = 1'b0;
            data_valid_s = 1'b0;
            if (mem_idx_r == MEM_LAST) begin
              state_s = DONE;
              done_s  = 1'b1;
            end else begin
              state_s     = MEM_REQ;
              mem_idx_s   = mem_idx_r + NB_MEM_ADDR'(1);
              mem_rd_en_s = 1'b1;
            end
          end else begin
            state_s = MEM_HOLD;
          end
        end
        DONE: begin
          done_s       = 1'b1;
          data_valid_s = 1'b0;
        end
        default: begin
          state_s      = REGS;
          reg_idx_s    = {NB_REG_ADDR{1'b0}};
          mem_idx_s    = {NB_MEM_ADDR{1'b0}};
          data_out_s   = {LEN{1'b0}};
          data_valid_s = 1'b0;
          done_s       = 1'b0;
          pending_s    = 1'b0;
        end
      endcase
    end
  end

  assign reg_addr   = reg_idx_r;
  assign mem_addr   = mem_idx_r;
  assign mem_rd_en  = mem_rd_en_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign done       = done_r;

endmodule

// File: tb/tb_debug_recolector.sv
// Scoreboard bench for debug_recolector: expected words queued as pointer
// changes are driven, popped on each rising data_valid.
module tb_debug_recolector;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic        send_regs;
  logic        enable_next;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [3:0]  mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_data;
  logic [31:0] data_out;
  logic        data_valid;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  logic        valid_q = 1'b0;
  logic [31:0] sb_q[$];

  debug_recolector dut (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .send_regs   (send_regs),
    .enable_next (enable_next),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_data    (mem_data),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Register file: combinational read; data memory: one-cycle synchronous read
  assign reg_data = 32'h1000_0000 + 32'(reg_addr);
  logic [31:0] mem_q = 32'h0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_q <= 32'hA000_0000 + 32'(mem_addr);
  end
  assign mem_data = mem_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on each new valid word; also counts read strobes
  always @(negedge clk) begin
    if (data_valid && !valid_q) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
      else check("sb_data", data_out, sb_q.pop_front());
    end
    valid_q <= data_valid;
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_next();
    enable_next = 1'b1;
    @(negedge clk);
    enable_next = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; restart = 1'b0; send_regs = 1'b1; enable_next = 1'b0;
    cyc(3);
    check("rst_data_out", data_out, 32'h0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    sb_q.push_back(32'h1000_0000);
    reset = 1'b0;
    @(negedge clk);
    check("reg0_valid", 32'(data_valid), 32'd1);
    check("reg0_addr", 32'(reg_addr), 32'd0);
    check("reg0_done", 32'(done), 32'd0);

    for (int i = 1; i <= 5; i++) begin
      sb_q.push_back(32'h1000_0000 + 32'(i));
      pulse_next();
      check("reg_valid_drop", 32'(data_valid), 32'd0);
      @(negedge clk);
      check("reg_valid_back", 32'(data_valid), 32'd1);
      cyc(8);
    end
    check("reg5_addr", 32'(reg_addr), 32'd5);
    check("reg5_data", data_out, 32'h1000_0005);

    for (int i = 6; i <= 31; i++) begin
      sb_q.push_back(32'h1000_0000 + 32'(i));
      pulse_next();
      cyc(1);
    end
    check("reg31_addr", 32'(reg_addr), 32'd31);

    // Last-register advance and send_regs low together, then two early pulses
    sb_q.push_back(32'hA000_0000);
    sb_q.push_back(32'hA000_0001);
    enable_next = 1'b1; send_regs = 1'b0;
    @(negedge clk);
    check("req_rd_en", 32'(mem_rd_en), 32'd1);
    check("req_addr", 32'(mem_addr), 32'd0);
    check("req_valid", 32'(data_valid), 32'd0);
    @(negedge clk);
    check("wait_rd_en", 32'(mem_rd_en), 32'd0);
    check("wait_valid", 32'(data_valid), 32'd0);
    enable_next = 1'b0;
    @(negedge clk);
    check("hold_valid", 32'(data_valid), 32'd1);
    check("hold_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("pend_valid", 32'(data_valid), 32'd0);
    check("pend_addr", 32'(mem_addr), 32'd1);
    check("pend_rd_en", 32'(mem_rd_en), 32'd1);
    cyc(10);
    check("pend_hold_addr", 32'(mem_addr), 32'd1);
    check("pend_hold_valid", 32'(data_valid), 32'd1);
    check("pend_rd_cnt", 32'(rd_cnt), 32'd2);

    for (int k = 2; k <= 15; k++) begin
      sb_q.push_back(32'hA000_0000 + 32'(k));
      pulse_next();
      cyc(4);
    end
    check("mem15_addr", 32'(mem_addr), 32'd15);
    pulse_next();
    check("done_flag", 32'(done), 32'd1);
    check("done_valid", 32'(data_valid), 32'd0);
    check("done_data", data_out, 32'hA000_000F);
    pulse_next();
    send_regs = 1'b1;
    cyc(3);
    check("done_stay", 32'(done), 32'd1);
    check("done_data_hold", data_out, 32'hA000_000F);
    check("done_addr_hold", 32'(mem_addr), 32'd15);
    check("done_rd_cnt", 32'(rd_cnt), 32'd16);

    // Restart from DONE
    sb_q.push_back(32'h1000_0000);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_done_reg_addr", 32'(reg_addr), 32'd0);
    check("rs_done_done", 32'(done), 32'd0);
    check("rs_done_rd_en", 32'(mem_rd_en), 32'd0);
    check("rs_done_valid", 32'(data_valid), 32'd0);
    @(negedge clk);
    check("rs_done_valid1", 32'(data_valid), 32'd1);
    cyc(3);

    // Restart in MEM_WAIT
    send_regs = 1'b0;
    cyc(2);
    check("rs_wait_rd_en", 32'(mem_rd_en), 32'd0);
    sb_q.push_back(32'h1000_0000);
    restart = 1'b1; send_regs = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_wait_reg_addr", 32'(reg_addr), 32'd0);
    check("rs_wait_done", 32'(done), 32'd0);
    check("rs_wait_rd_en", 32'(mem_rd_en), 32'd0);
    check("rs_wait_data", data_out, 32'h0);
    @(negedge clk);
    check("rs_wait_valid1", 32'(data_valid), 32'd1);
    cyc(2);
    check("sb_left", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
